// File: rtl/data_mem_responder.sv
// Responder for the CPU MEM-stage data port: a word-addressed RAM that serves one access
// at a time with a fixed wait latency, stalls the pipeline meanwhile and flags illegal requests.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [15:0] acc_count
);

    localparam int          DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    is_write_q, is_write_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             mem_din_q, mem_din_d;
    logic                    mem_err_q, mem_err_d;
    logic [15:0]             acc_count_q, acc_count_d;

    logic                    req;
    logic                    bad;
    logic                    access;
    logic                    ram_we;

    logic [31:0]             ram [DEPTH];

    assign req = mem_ren | mem_wen;
    assign bad = (mem_ren & mem_wen)
               | (mem_addr[1:0] != 2'b00)
               | (|mem_addr[31:ADDR_WIDTH+2]);

    // The array is touched exactly once per legal request, on the last wait cycle.
    assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign ram_we = access && is_write_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        mem_din_d   = mem_din_q;
        mem_err_d   = 1'b0;
        acc_count_d = acc_count_q;
        mem_stall   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req && !bad) begin
                    is_write_d = mem_wen;
                    idx_d      = mem_addr[ADDR_WIDTH+1:2];
                    wdata_d    = mem_dout;
                    cnt_d      = CNT_INIT;
                    mem_stall  = 1'b1;
                    state_d    = ST_WAIT;
                end else if (req) begin
                    mem_err_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!is_write_q) begin
                        mem_din_d = ram[idx_q];
                    end
                    acc_count_d = acc_count_q + 16'd1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            is_write_q  <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            mem_din_q   <= 32'd0;
            mem_err_q   <= 1'b0;
            acc_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            mem_din_q   <= mem_din_d;
            mem_err_q   <= mem_err_d;
            acc_count_q <= acc_count_d;
        end
    end

    // RAM contents survive reset, but a reset on the access edge must drop the pending write.
    always_ff @(posedge clk) begin
        if (rst_n && ram_we) begin
            ram[idx_q] <= wdata_q;
        end
    end

    assign mem_din   = mem_din_q;
    assign mem_err   = mem_err_q;
    assign acc_count = acc_count_q;

endmodule
